// File: rtl/hazard_if.sv
// Hazard-unit bus: every pipeline-register field the hazard unit observes and
// every control it returns to the pipeline. Signal prefixes are written from
// the hazard unit's point of view: i_ signals flow into it and o_ signals flow out.
interface hazard_if #(
  parameter int CNT_W = 16
);
  // IF/ID source registers
  logic [4:0]       i_id_rs1;
  logic [4:0]       i_id_rs2;
  // ID/EX fields
  logic             i_idex_memread;
  logic             i_idex_halt;
  logic [4:0]       i_idex_rd;
  logic [4:0]       i_idex_rs1;
  logic [4:0]       i_idex_rs2;
  // EX/MEM and MEM/WB write-back fields
  logic             i_exmem_regwrite;
  logic [4:0]       i_exmem_rd;
  logic             i_memwb_regwrite;
  logic [4:0]       i_memwb_rd;
  // Branch resolution from EX
  logic             i_ex_branch_taken;
  // Pipeline control returned by the hazard unit
  logic             o_pc_write;
  logic             o_ifid_write;
  logic             o_ifid_flush;
  logic             o_idex_bubble;
  logic [1:0]       o_fwd_a;
  logic [1:0]       o_fwd_b;
  logic             o_halted;
  logic [CNT_W-1:0] o_event_cnt;

  // Pipeline side: drives the register fields and consumes the controls
  modport master (
    output i_id_rs1, i_id_rs2,
    output i_idex_memread, i_idex_halt, i_idex_rd, i_idex_rs1, i_idex_rs2,
    output i_exmem_regwrite, i_exmem_rd, i_memwb_regwrite, i_memwb_rd,
    output i_ex_branch_taken,
    input  o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble,
    input  o_fwd_a, o_fwd_b, o_halted, o_event_cnt
  );

  // Hazard-unit side
  modport slave (
    input  i_id_rs1, i_id_rs2,
    input  i_idex_memread, i_idex_halt, i_idex_rd, i_idex_rs1, i_idex_rs2,
    input  i_exmem_regwrite, i_exmem_rd, i_memwb_regwrite, i_memwb_rd,
    input  i_ex_branch_taken,
    output o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble,
    output o_fwd_a, o_fwd_b, o_halted, o_event_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard unit for a classic 5-stage pipeline: load-use stalls, taken-branch
// flushes, EX-stage operand forwarding, and a halt sequence that drains
// EX/MEM/WB before reporting the pipeline as halted.
// All pipeline controls are combinational from the current state and the
// pipeline-register fields, so a stall or flush acts in the same cycle as
// the hazard is seen. The only sequential state is the FSM state, the drain
// counter and the saturating stall/flush event counter.
module hazard_unit #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic     clk,
  input  logic     reset,
  hazard_if.slave  bus
);

  // Drain counter width; at least one bit even for a single drain cycle
  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Forwarding source select for one ALU operand. EX/MEM has the newer
  // value, so it is checked first; x0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] f_fwd_sel(
    input logic       exm_rw,
    input logic [4:0] exm_rd,
    input logic       wb_rw,
    input logic [4:0] wb_rd,
    input logic [4:0] rs
  );
    logic [1:0] sel;
    if (exm_rw && (exm_rd != 5'd0) && (exm_rd == rs)) begin
      sel = 2'b10;
    end else if (wb_rw && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // A load in EX whose destination is read by the instruction in ID cannot
  // be forwarded in time; the consumer has to wait one cycle.
  function automatic logic f_load_use(
    input logic       memread,
    input logic [4:0] ld_rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    logic hit;
    if (memread && (ld_rd != 5'd0)) begin
      hit = (ld_rd == rs1) || (ld_rd == rs2);
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic [DW-1:0]    r_drain_cnt;
  logic [DW-1:0]    w_next_drain_cnt;
  logic [CNT_W-1:0] r_event_cnt;

  logic             w_load_use;
  logic             w_count_evt;
  logic             w_pc_write;
  logic             w_ifid_write;
  logic             w_ifid_flush;
  logic             w_idex_bubble;
  logic             w_halted;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  assign w_load_use = f_load_use(bus.i_idex_memread, bus.i_idex_rd,
                                 bus.i_id_rs1, bus.i_id_rs2);

  // Operand forwarding is independent of the FSM state
  always_comb begin
    w_fwd_a = f_fwd_sel(bus.i_exmem_regwrite, bus.i_exmem_rd,
                        bus.i_memwb_regwrite, bus.i_memwb_rd, bus.i_idex_rs1);
    w_fwd_b = f_fwd_sel(bus.i_exmem_regwrite, bus.i_exmem_rd,
                        bus.i_memwb_regwrite, bus.i_memwb_rd, bus.i_idex_rs2);
  end

  // FSM state and drain counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= {DW{1'b0}};
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_next_drain_cnt;
    end
  end

  // Next-state logic and pipeline controls; priority in RUN is halt, then
  // taken branch, then load-use stall
  always_comb begin
    w_next_state     = r_state;
    w_next_drain_cnt = r_drain_cnt;
    w_pc_write       = 1'b1;
    w_ifid_write     = 1'b1;
    w_ifid_flush     = 1'b0;
    w_idex_bubble    = 1'b0;
    w_halted         = 1'b0;
    w_count_evt      = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (bus.i_idex_halt) begin
          // Freeze fetch and squash everything younger than the halt
          w_pc_write       = 1'b0;
          w_ifid_write     = 1'b0;
          w_ifid_flush     = 1'b1;
          w_idex_bubble    = 1'b1;
          w_next_state     = ST_DRAIN;
          w_next_drain_cnt = DRAIN_LOAD;
        end else if (bus.i_ex_branch_taken) begin
          // Wrong-path instructions in IF/ID and ID/EX are discarded while
          // the PC moves to the branch target; any load-use stall is moot
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
          w_count_evt   = 1'b1;
        end else if (w_load_use) begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
          w_count_evt   = 1'b1;
        end else begin
          w_count_evt   = 1'b0;
        end
      end

      ST_DRAIN: begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_ifid_flush  = 1'b1;
        w_idex_bubble = 1'b1;
        if (r_drain_cnt == {DW{1'b0}}) begin
          w_next_state = ST_HALTED;
        end else begin
          w_next_drain_cnt = r_drain_cnt - DW'(1);
        end
      end

      ST_HALTED: begin
        // Terminal until reset; pipeline inputs are deliberately ignored
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_ifid_flush  = 1'b1;
        w_idex_bubble = 1'b1;
        w_halted      = 1'b1;
      end

      default: begin
        // Unreachable encoding: hold the pipeline and recover to RUN
        w_pc_write       = 1'b0;
        w_ifid_write     = 1'b0;
        w_ifid_flush     = 1'b1;
        w_idex_bubble    = 1'b1;
        w_next_state     = ST_RUN;
        w_next_drain_cnt = {DW{1'b0}};
      end
    endcase
  end

  // Saturating count of RUN-state stall and flush cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_event_cnt <= {CNT_W{1'b0}};
    end else if (w_count_evt && (r_event_cnt != CNT_MAX)) begin
      r_event_cnt <= r_event_cnt + CNT_W'(1);
    end else begin
      r_event_cnt <= r_event_cnt;
    end
  end

  assign bus.o_pc_write    = w_pc_write;
  assign bus.o_ifid_write  = w_ifid_write;
  assign bus.o_ifid_flush  = w_ifid_flush;
  assign bus.o_idex_bubble = w_idex_bubble;
  assign bus.o_fwd_a       = w_fwd_a;
  assign bus.o_fwd_b       = w_fwd_b;
  assign bus.o_halted      = w_halted;
  assign bus.o_event_cnt   = r_event_cnt;

endmodule
